// File: rtl/rv32m_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with single-cycle divide fast paths.
module rv32m_mdu #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            flush,
    input  logic            start,
    input  logic            mul,
    input  logic            div,
    input  logic            rem,
    input  logic            usign_usign,
    input  logic            sign_sign,
    input  logic            sign_usign,
    input  logic            lower_word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      CNT_LAST = 5'(XLEN - 1);

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2*XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                is_rem_q, is_rem_d;
    logic                lower_q, lower_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                rs1_signed_s, rs2_signed_s;
    logic                rs1_neg_s, rs2_neg_s;
    logic [XLEN-1:0]     rs1_mag_s, rs2_mag_s;
    logic                accept_s;
    logic                last_s;
    logic [2*XLEN-1:0]   mul_acc_s, mul_prod_s;
    logic [XLEN:0]       div_trial_s, div_diff_s;
    logic [2*XLEN-1:0]   div_acc_s;
    logic [XLEN-1:0]     div_quo_s, div_rem_s;

    // Operand decode, magnitude conversion and one iteration step of each datapath
    always_comb begin
        rs1_signed_s = !usign_usign && (mul ? (sign_sign || sign_usign) : sign_sign);
        rs2_signed_s = !usign_usign && sign_sign;
        rs1_neg_s    = rs1_signed_s && rs1_data[XLEN-1];
        rs2_neg_s    = rs2_signed_s && rs2_data[XLEN-1];
        rs1_mag_s    = rs1_neg_s ? (~rs1_data + 1'b1) : rs1_data;
        rs2_mag_s    = rs2_neg_s ? (~rs2_data + 1'b1) : rs2_data;
        accept_s     = start && (mul || div) && (state_q == IDLE || state_q == DONE);
        last_s       = (cnt_q == CNT_LAST);

        mul_acc_s    = b_q[0] ? (acc_q + a_q) : acc_q;
        mul_prod_s   = neg_q ? (~mul_acc_s + 1'b1) : mul_acc_s;

        // Partial remainder shifted left with the next dividend bit; no borrow means it fits
        div_trial_s  = acc_q[2*XLEN-1:XLEN-1];
        div_diff_s   = div_trial_s - {1'b0, b_q};
        div_acc_s    = !div_diff_s[XLEN] ? {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                         : {acc_q[2*XLEN-2:0], 1'b0};
        div_quo_s    = neg_q  ? (~div_acc_s[XLEN-1:0] + 1'b1) : div_acc_s[XLEN-1:0];
        div_rem_s    = rneg_q ? (~div_acc_s[2*XLEN-1:XLEN] + 1'b1) : div_acc_s[2*XLEN-1:XLEN];
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        is_rem_d = is_rem_q;
        lower_d  = lower_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    cnt_d    = 5'd0;
                    is_rem_d = rem;
                    lower_d  = lower_word;
                    neg_d    = rs1_neg_s ^ rs2_neg_s;
                    rneg_d   = rs1_neg_s;
                    if (mul) begin
                        state_d = MUL;
                        a_d     = {{XLEN{1'b0}}, rs1_mag_s};
                        b_d     = rs2_mag_s;
                        acc_d   = {(2*XLEN){1'b0}};
                        busy_d  = 1'b1;
                    end else if (rs2_data == {XLEN{1'b0}}) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = rem ? rs1_data : ALL_ONES;
                    end else if (rs2_signed_s && rs1_data == MIN_NEG && rs2_data == ALL_ONES) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = rem ? {XLEN{1'b0}} : MIN_NEG;
                    end else begin
                        state_d = DIV;
                        b_d     = rs2_mag_s;
                        acc_d   = {{XLEN{1'b0}}, rs1_mag_s};
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d = mul_acc_s;
                a_d   = {a_q[2*XLEN-2:0], 1'b0};
                b_d   = {1'b0, b_q[XLEN-1:1]};
                cnt_d = cnt_q + 5'd1;
                if (last_s) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = lower_q ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];
                end else begin
                    busy_d = 1'b1;
                end
            end
            DIV: begin
                acc_d = div_acc_s;
                cnt_d = cnt_q + 5'd1;
                if (last_s) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = is_rem_q ? div_rem_s : div_quo_s;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            a_q      <= {(2*XLEN){1'b0}};
            b_q      <= {XLEN{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            is_rem_q <= 1'b0;
            lower_q  <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            is_rem_q <= is_rem_d;
            lower_q  <= lower_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
